// File: rtl/vending_pkg.sv
// Shared types and constants for the single-product coin vending controller.
// Credit held between coins is encoded directly by the state value.
package vending_pkg;

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } state_t;

  localparam logic [3:0] PRICE     = 4'd5;
  localparam logic [3:0] COIN_ONE  = 4'd1;
  localparam logic [3:0] COIN_TWO  = 4'd2;
  localparam logic [3:0] COIN_FIVE = 4'd5;

endpackage

// File: rtl/vending_machine_fsm_if.sv
// Coin strobes from the validator front end and dispense/change outputs
// to the actuators.
interface vending_machine_fsm_if;

  logic       one;
  logic       two;
  logic       five;
  logic       d;
  logic [2:0] r;

  modport master (
    output one,
    output two,
    output five,
    input  d,
    input  r
  );

  modport slave (
    input  one,
    input  two,
    input  five,
    output d,
    output r
  );

endinterface

// File: rtl/vending_machine_fsm.sv
// Vending controller: sums simultaneous coin strobes onto the held credit and
// dispenses one item with all excess returned as change once the price is met.
module vending_machine_fsm
  import vending_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  vending_machine_fsm_if.slave bus
);

  state_t     state;
  state_t     state_next;
  logic       d_next;
  logic [2:0] r_next;
  logic [3:0] coin_value;
  logic [3:0] total;
  logic [3:0] change;

  // Coins arriving together are summed, never prioritised; max total is 4+8=12.
  always_comb begin
    state_next = state;
    d_next     = 1'b0;
    r_next     = 3'd0;
    coin_value = (bus.one  ? COIN_ONE  : 4'd0)
               + (bus.two  ? COIN_TWO  : 4'd0)
               + (bus.five ? COIN_FIVE : 4'd0);
    total      = {1'b0, state} + coin_value;
    change     = total - PRICE;

    if (state > S4) begin
      state_next = S0;
    end else if (total >= PRICE) begin
      state_next = S0;
      d_next     = 1'b1;
      r_next     = change[2:0];
    end else begin
      state_next = state_t'(total[2:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S0;
      bus.d <= 1'b0;
      bus.r <= 3'd0;
    end else begin
      state <= state_next;
      bus.d <= d_next;
      bus.r <= r_next;
    end
  end

endmodule

// File: tb/tb_vending_machine_fsm.sv
// Scoreboard bench: each stimulus cycle queues the hand-computed d/r expected
// after that edge; an independent monitor pops and compares one entry per cycle.
module tb_vending_machine_fsm;

  typedef struct {
    logic       d;
    logic [2:0] r;
    string      name;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  exp_t scoreboard[$];

  vending_machine_fsm_if bus ();

  vending_machine_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic o, input logic t, input logic f,
                               input logic rs, input logic ed,
                               input logic [2:0] er, input string name);
    exp_t e;
    @(negedge clk);
    reset    = rs;
    bus.one  = o;
    bus.two  = t;
    bus.five = f;
    e.d = ed;
    e.r = er;
    e.name = name;
    scoreboard.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    checks++;
    if (bus.d !== e.d || bus.r !== e.r) begin
      errors++;
      $display("[TB] FAIL %s: got d=%0b r=%0d, expected d=%0b r=%0d",
               e.name, bus.d, bus.r, e.d, e.r);
    end
  endtask

  // Outputs are registered, so each queued entry is due just after the next edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (scoreboard.size() > 0) begin
        e = scoreboard.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    reset    = 1'b1;
    bus.one  = 1'b0;
    bus.two  = 1'b0;
    bus.five = 1'b0;

    //            one  two  five rst   d    r
    applyStimulus(1'b0,1'b0,1'b0,1'b1, 1'b0,3'd0, "reset");
    applyStimulus(1'b1,1'b0,1'b0,1'b0, 1'b0,3'd0, "seq1_one");
    applyStimulus(1'b0,1'b1,1'b0,1'b0, 1'b0,3'd0, "seq1_two");
    applyStimulus(1'b0,1'b1,1'b0,1'b0, 1'b1,3'd0, "seq1_dispense");
    applyStimulus(1'b0,1'b0,1'b0,1'b0, 1'b0,3'd0, "seq1_idle");

    applyStimulus(1'b0,1'b0,1'b1,1'b0, 1'b1,3'd0, "five_from_s0");
    applyStimulus(1'b0,1'b0,1'b0,1'b0, 1'b0,3'd0, "five_clear");

    applyStimulus(1'b0,1'b1,1'b0,1'b0, 1'b0,3'd0, "ttt_1");
    applyStimulus(1'b0,1'b1,1'b0,1'b0, 1'b0,3'd0, "ttt_2_s4");
    applyStimulus(1'b0,1'b1,1'b0,1'b0, 1'b1,3'd1, "ttt_3_change1");
    applyStimulus(1'b0,1'b0,1'b0,1'b0, 1'b0,3'd0, "ttt_clear");

    applyStimulus(1'b0,1'b1,1'b0,1'b0, 1'b0,3'd0, "max_two_a");
    applyStimulus(1'b0,1'b1,1'b0,1'b0, 1'b0,3'd0, "max_two_b");
    applyStimulus(1'b1,1'b1,1'b1,1'b0, 1'b1,3'd7, "max_sum12");
    applyStimulus(1'b0,1'b0,1'b0,1'b0, 1'b0,3'd0, "max_clear");

    applyStimulus(1'b0,1'b1,1'b0,1'b0, 1'b0,3'd0, "rst_two");
    applyStimulus(1'b1,1'b0,1'b0,1'b0, 1'b0,3'd0, "rst_one");
    applyStimulus(1'b0,1'b1,1'b0,1'b1, 1'b0,3'd0, "rst_with_two");
    applyStimulus(1'b0,1'b0,1'b1,1'b0, 1'b1,3'd0, "rst_then_five");

    applyStimulus(1'b0,1'b0,1'b1,1'b0, 1'b1,3'd0, "held_five_1");
    applyStimulus(1'b0,1'b0,1'b1,1'b0, 1'b1,3'd0, "held_five_2");
    applyStimulus(1'b0,1'b0,1'b1,1'b0, 1'b1,3'd0, "held_five_3");
    applyStimulus(1'b0,1'b0,1'b0,1'b0, 1'b0,3'd0, "idle_a");
    applyStimulus(1'b0,1'b0,1'b0,1'b0, 1'b0,3'd0, "idle_b");

    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1,1'b0,1'b0,1'b0, 1'b0,3'd0, "ones_accum");
    applyStimulus(1'b0,1'b0,1'b1,1'b0, 1'b1,3'd4, "s4_plus_five");

    applyStimulus(1'b1,1'b0,1'b0,1'b0, 1'b0,3'd0, "c3_one");
    applyStimulus(1'b0,1'b1,1'b0,1'b0, 1'b0,3'd0, "c3_two");
    applyStimulus(1'b0,1'b1,1'b1,1'b0, 1'b1,3'd5, "c3_plus_seven");
    applyStimulus(1'b1,1'b1,1'b0,1'b0, 1'b0,3'd0, "after_dispense_three");
    applyStimulus(1'b0,1'b1,1'b0,1'b0, 1'b1,3'd0, "three_plus_two");

    applyStimulus(1'b0,1'b0,1'b0,1'b0, 1'b0,3'd0, "final_idle");

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (scoreboard.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending entries, expected 0",
               scoreboard.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
